pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the 12-bit program counter register and computes the next fetch address.
//  Consumes the return/target address coming back from the register file for JR/RET.
//  Sits between decode (operation, immediate, zero flag) and instruction memory.
//  Counterpart of the link path that writes PC+1 into the register file.
// PARAMETERS
//  PC_WIDTH      12      program counter width
//  RESET_VECTOR  12'h000 first fetch address after reset
//  STACK_DEPTH   4       link-stack entries (used only with PC_LINK_STACK_EN)
// PORTS
//  clock             in   1         single system clock, rising edge
//  reset             in   1         asynchronous, active-low reset
//  enable            in   1         1 = advance PC this cycle; 0 = stall (hold everything)
//  operation         in   6         opcode of the instruction at program_counter
//  immediate         in   PC_WIDTH  absolute target for JMP/JAL/BZ/BNZ
//  register_value    in   PC_WIDTH  target read from register file for JR (and RET without stack)
//  zero_flag         in   1         ALU zero result, sampled for BZ/BNZ
//  resume            in   1         leaves HALT; next PC = halted PC + 1
//  program_counter   out  PC_WIDTH  current fetch address (registered)
//  halted            out  1         1 while in HALT
//  stack_error       out  1         1-cycle pulse on link-stack overflow/underflow
// BEHAVIOUR
//  Reset (async assert, sync release): program_counter=RESET_VECTOR, state=RUN,
//    halted=0, stack_error=0, stack pointer=0, all stack entries=0.
//  State machine: RUN, HALT. Latency: one clock from operation to new program_counter.
//  RUN, enable=1, by operation:
//   op < 6'h12 or op == 6'h17 -> PC+1 (wraps 12'hFFF -> 12'h000)
//   OP_JMP 6'h12 -> immediate        OP_JR  6'h13 -> register_value
//   OP_BZ  6'h14 -> zero_flag ? immediate : PC+1
//   OP_BNZ 6'h15 -> zero_flag ? PC+1 : immediate
//   OP_JAL 6'h16 -> immediate (link value PC+1 is written by the register-file path)
//   OP_HLT 6'h18 -> PC held, state -> HALT, halted=1 next cycle
//   OP_RET 6'h19 -> see CONFIGURATION
//   any other opcode -> PC+1
//  RUN, enable=0: PC, state and stack unchanged; stack_error=0.
//  HALT: PC held regardless of enable/operation; resume=1 -> PC+1, state RUN, halted=0.
//    resume=0 in RUN is ignored. enable=0 in HALT does not block resume.
//  All arithmetic is modulo 2^PC_WIDTH; no carry out.
//  Reset asserted mid-stall or mid-HALT: immediate return to reset values.
// CONFIGURATION
//  PC_LINK_STACK_EN defined: STACK_DEPTH-entry hardware return stack.
//   JAL pushes PC+1; RET pops and jumps to the popped value (register_value ignored).
//   Push when full: oldest entry overwritten (circular), stack_error pulses 1.
//   Pop when empty: jump to register_value, pointer unchanged, stack_error pulses 1.
//   Push/pop only when RUN and enable=1.
//  PC_LINK_STACK_EN undefined: no stack storage; RET behaves exactly as JR;
//   stack_error tied 0.
// STRUCTURE
//  Package pc_sequencer_pkg: opcode constants OP_JMP..OP_RET, state encoding
//   (RUN=1'b0, HALT=1'b1), PC_WIDTH default.
//  Sub-module link_stack (circular LIFO: push, pop, data_out, full, empty, error),
//   instantiated only under PC_LINK_STACK_EN.
//  Top level: next-PC mux, PC register, two-state FSM.
// TESTING
//  1 Reset release, op=6'h00, enable=1 x3 -> PC 000,001,002,003; halted=0.
//  2 PC=FFF, op=6'h05 -> PC=000 (wrap); op=6'h12, imm=0A5 -> PC=0A5.
//  3 PC=010, op=BZ, imm=040, zero=1 -> 040; from 040 op=BNZ, zero=1 -> 041.
//  4 PC=020, op=HLT -> halted=1, PC stays 020 for 5 cycles with enable toggling;
//    resume=1 -> PC=021, halted=0.
//  5 enable=0 with op=JMP imm=100 -> PC unchanged; reset pulsed during HALT -> PC=RESET_VECTOR.
//  6 (PC_LINK_STACK_EN) 5 nested JAL from PC=000,100,200,300,400 -> 5th push
//    stack_error=1; 4 RETs -> 401,301,201,101; 5th RET, register_value=077 ->
//    PC=077, stack_error=1. Without macro: RET, register_value=077 -> PC=077, no error.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: opcode constants, FSM state encoding and default PC width
package pc_sequencer_pkg;
  localparam int DEFAULT_PC_WIDTH = 12;
  localparam logic [5:0] OP_JMP = 6'h12;
  localparam logic [5:0] OP_JR  = 6'h13;
  localparam logic [5:0] OP_BZ  = 6'h14;
  localparam logic [5:0] OP_BNZ = 6'h15;
  localparam logic [5:0] OP_JAL = 6'h16;
  localparam logic [5:0] OP_HLT = 6'h18;
  localparam logic [5:0] OP_RET = 6'h19;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/pc_sequencer_link_stack.sv
// link_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module link_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_error
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data  = r_mem[r_ptr - 1'b1];
  assign o_error = (i_push && o_full) || (i_pop && o_empty);
  // r_ptr is the next free slot; once full that slot holds the oldest entry
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_data;
      r_ptr <= r_ptr + 1'b1;
      r_cnt <= o_full ? r_cnt : r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter register, next-PC mux and RUN/HALT FSM.
// Define PC_LINK_STACK_EN to add a hardware return stack for JAL/RET.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                STACK_DEPTH  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [5:0]          i_operation,
  input  logic [PC_WIDTH-1:0] i_immediate,
  input  logic [PC_WIDTH-1:0] i_register_value,
  input  logic                i_zero_flag,
  input  logic                i_resume,
  output logic [PC_WIDTH-1:0] o_program_counter,
  output logic                o_halted,
  output logic                o_stack_error
);
  state_t              r_state, w_next_state;
  logic [PC_WIDTH-1:0] r_pc, w_next_pc, w_pc_inc, w_ret_pc;
  logic                r_stack_error, w_push, w_pop, w_stack_error;
`ifdef PC_LINK_STACK_EN
  logic [PC_WIDTH-1:0] w_pop_data;
  logic                w_full, w_empty;
  link_stack #(.WIDTH(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_link_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_pop_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_error (w_stack_error)
  );
  assign w_ret_pc = w_empty ? i_register_value : w_pop_data;
`else
  assign w_stack_error = 1'b0;
  assign w_ret_pc = i_register_value;
`endif
  assign w_pc_inc = r_pc + 1'b1;
  always_comb begin
    w_next_pc    = r_pc;
    w_next_state = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    if (r_state == HALT) begin
      w_next_pc    = i_resume ? w_pc_inc : r_pc;
      w_next_state = i_resume ? RUN : HALT;
    end else if (i_enable) begin
      case (i_operation)
        OP_JMP:  w_next_pc = i_immediate;
        OP_JR:   w_next_pc = i_register_value;
        OP_BZ:   w_next_pc = i_zero_flag ? i_immediate : w_pc_inc;
        OP_BNZ:  w_next_pc = i_zero_flag ? w_pc_inc : i_immediate;
        OP_JAL:  begin
          w_next_pc = i_immediate;
          w_push    = 1'b1;
        end
        OP_HLT:  w_next_state = HALT;
        OP_RET:  begin
          w_next_pc = w_ret_pc;
          w_pop     = 1'b1;
        end
        default: w_next_pc = w_pc_inc;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pc          <= RESET_VECTOR;
      r_state       <= RUN;
      r_stack_error <= 1'b0;
    end else begin
      r_pc          <= w_next_pc;
      r_state       <= w_next_state;
      r_stack_error <= w_stack_error;
    end
  assign o_program_counter = r_pc;
  assign o_halted          = r_state == HALT;
  assign o_stack_error     = r_stack_error;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors checked every cycle against a behavioural model,
// plus literal expectations; define PC_LINK_STACK_EN to exercise the return stack.
module tb_pc_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0, zero_flag = 1'b0, resume = 1'b0;
  logic [5:0]  operation = '0;
  logic [11:0] immediate = '0, register_value = '0;
  logic [11:0] program_counter;
  logic        halted, stack_error;
  int          n_pass = 0, n_total = 0;
  logic [11:0] m_pc;
  logic        m_halt, m_err;
  logic [11:0] m_stack[$];

  pc_sequencer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_operation      (operation),
    .i_immediate      (immediate),
    .i_register_value (register_value),
    .i_zero_flag      (zero_flag),
    .i_resume         (resume),
    .o_program_counter(program_counter),
    .o_halted         (halted),
    .o_stack_error    (stack_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pc = 12'h000;
      m_halt = 1'b0;
      m_err = 1'b0;
      m_stack.delete();
    end else begin
      m_err = 1'b0;
      if (m_halt) begin
        if (resume) begin
          m_pc = m_pc + 12'd1;
          m_halt = 1'b0;
        end
      end else if (enable) begin
        if (operation == 6'h12) m_pc = immediate;
        else if (operation == 6'h13) m_pc = register_value;
        else if (operation == 6'h14) m_pc = zero_flag ? immediate : m_pc + 12'd1;
        else if (operation == 6'h15) m_pc = zero_flag ? m_pc + 12'd1 : immediate;
        else if (operation == 6'h16) begin
`ifdef PC_LINK_STACK_EN
          if (m_stack.size() == 4) begin
            void'(m_stack.pop_front());
            m_err = 1'b1;
          end
          m_stack.push_back(m_pc + 12'd1);
`endif
          m_pc = immediate;
        end else if (operation == 6'h18) m_halt = 1'b1;
        else if (operation == 6'h19) begin
`ifdef PC_LINK_STACK_EN
          if (m_stack.size() == 0) begin
            m_pc = register_value;
            m_err = 1'b1;
          end else m_pc = m_stack.pop_back();
`else
          m_pc = register_value;
`endif
        end else m_pc = m_pc + 12'd1;
      end
    end

  always @(negedge clk) begin
    chk("model_pc", {20'd0, program_counter}, {20'd0, m_pc});
    chk("model_halted", {31'd0, halted}, {31'd0, m_halt});
    chk("model_stack_error", {31'd0, stack_error}, {31'd0, m_err});
  end

  task automatic step(input logic [5:0] op, input logic [11:0] imm, input logic [11:0] rv,
                      input logic z, input logic en, input logic res);
    operation = op;
    immediate = imm;
    register_value = rv;
    zero_flag = z;
    enable = en;
    resume = res;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_pc", {20'd0, program_counter}, 32'h000);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", {20'd0, program_counter}, 32'h000);
    chk("reset_err", {31'd0, stack_error}, 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(6'h00, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
      chk("seq_pc", {20'd0, program_counter}, i);
    end
    chk("seq_halted", {31'd0, halted}, 32'd0);
    step(6'h12, 12'hFFF, 12'h0, 1'b0, 1'b1, 1'b0);
    step(6'h05, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("wrap", {20'd0, program_counter}, 32'h000);
    step(6'h12, 12'h0A5, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("jmp", {20'd0, program_counter}, 32'h0A5);
    step(6'h12, 12'h010, 12'h0, 1'b0, 1'b1, 1'b0);
    step(6'h14, 12'h040, 12'h0, 1'b1, 1'b1, 1'b0);
    chk("bz_taken", {20'd0, program_counter}, 32'h040);
    step(6'h15, 12'h123, 12'h0, 1'b1, 1'b1, 1'b0);
    chk("bnz_not_taken", {20'd0, program_counter}, 32'h041);
    step(6'h14, 12'h777, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("bz_not_taken", {20'd0, program_counter}, 32'h042);
    step(6'h15, 12'h200, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("bnz_taken", {20'd0, program_counter}, 32'h200);
    step(6'h13, 12'h555, 12'h333, 1'b0, 1'b1, 1'b0);
    chk("jr", {20'd0, program_counter}, 32'h333);
    step(6'h17, 12'h555, 12'h0, 1'b0, 1'b1, 1'b0);
    step(6'h3F, 12'h555, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("op17_op3f", {20'd0, program_counter}, 32'h335);
    step(6'h16, 12'h020, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("jal", {20'd0, program_counter}, 32'h020);
    step(6'h18, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) step(6'h12, 12'h500, 12'h0, 1'b0, i[0], 1'b0);
    chk("hlt_hold_pc", {20'd0, program_counter}, 32'h020);
    step(6'h12, 12'h500, 12'h0, 1'b0, 1'b0, 1'b1);
    chk("resume_pc", {20'd0, program_counter}, 32'h021);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    step(6'h12, 12'h100, 12'h0, 1'b0, 1'b0, 1'b1);
    chk("stall", {20'd0, program_counter}, 32'h021);
    step(6'h18, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
    step(6'h00, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("post_reset_halted", {31'd0, halted}, 32'd0);
`ifdef PC_LINK_STACK_EN
    for (int i = 1; i <= 5; i++) step(6'h16, 12'(i * 256), 12'h0, 1'b0, 1'b1, 1'b0);
    chk("push_overflow_err", {31'd0, stack_error}, 32'd1);
    for (int i = 4; i >= 1; i--) begin
      step(6'h19, 12'h0, 12'h0EE, 1'b0, 1'b1, 1'b0);
      chk("ret_pop", {20'd0, program_counter}, 32'(i * 256 + 1));
      chk("ret_pop_err", {31'd0, stack_error}, 32'd0);
    end
    step(6'h19, 12'h0, 12'h077, 1'b0, 1'b1, 1'b0);
    chk("ret_underflow_pc", {20'd0, program_counter}, 32'h077);
    chk("ret_underflow_err", {31'd0, stack_error}, 32'd1);
`else
    step(6'h16, 12'h300, 12'h0, 1'b0, 1'b1, 1'b0);
    step(6'h19, 12'h0, 12'h077, 1'b0, 1'b1, 1'b0);
    chk("ret_as_jr", {20'd0, program_counter}, 32'h077);
    chk("ret_no_err", {31'd0, stack_error}, 32'd0);
`endif
    step(6'h00, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("err_clears", {31'd0, stack_error}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
